inst_queue: RTL and testbench



---
 rtl/inst_queue_pkg.sv | 29 ++
 rtl/iq_compactor.sv | 26 ++
 rtl/inst_queue.sv | 105 ++++++++++
 tb/tb_inst_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared instruction-queue types for the fetch/decode boundary.
// Also included by the decoder for entry layout and pointer width.
package inst_queue_pkg;

    localparam int IQ_DEPTH = 16;
    localparam int IQ_PTR_W = $clog2(IQ_DEPTH);

    typedef logic [IQ_PTR_W-1:0] iq_ptr_t;

    typedef struct packed {
        logic adef;
    } fetch_excp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } iq_entry_t;

    // PC of lane i inside an aligned fetch group
    function automatic logic [31:0] lane_pc(
        input logic [31:0] vpc,
        input int          lanes,
        input int          i
    );
        return (vpc & ~32'(lanes * 4 - 1)) | 32'(i * 4);
    endfunction

endpackage

// File: rtl/iq_compactor.sv
// Exclusive prefix popcount of a lane mask plus total set count.
// Gives each valid lane its slot offset relative to the queue tail.
module iq_compactor
    import inst_queue_pkg::*;
#(
    parameter int N = 2,
    localparam int W = $clog2(N + 1)
) (
    input  logic [N-1:0]        valid,
    output logic [N-1:0][W-1:0] offset,
    output logic [W-1:0]        total
);

    logic [W-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < N; i++) begin
            offset[i] = acc;
            acc       = acc + W'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/inst_queue.sv
// Decoupling FIFO between the icache fetch stage and decode:
// compacts valid fetch lanes into entries, offers the oldest in order.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int FETCH_SIZE          = 2,
    parameter int ISSUE_WIDTH         = 2,
    parameter int DEPTH               = IQ_DEPTH,
    parameter int ATTACHED_INFO_WIDTH = 32
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clr_i,
    input  logic [31:0]                                   vpc_i,
    input  logic [FETCH_SIZE-1:0]                         valid_i,
    input  logic [FETCH_SIZE-1:0][31:0]                   inst_i,
    input  logic [ATTACHED_INFO_WIDTH-1:0]                attached_i,
    input  fetch_excp_t                                   fetch_excp_i,
    output logic                                          ready_o,
    output logic [ISSUE_WIDTH-1:0]                        valid_o,
    output logic [ISSUE_WIDTH-1:0][31:0]                  pc_o,
    output logic [ISSUE_WIDTH-1:0][31:0]                  inst_o,
    output logic [ISSUE_WIDTH-1:0][ATTACHED_INFO_WIDTH-1:0] attached_o,
    output logic [ISSUE_WIDTH-1:0]                        adef_o,
    input  logic [ISSUE_WIDTH-1:0]                        ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(FETCH_SIZE + 1);
    localparam int DW = $clog2(ISSUE_WIDTH + 1);

    iq_entry_t                      ram     [DEPTH];
    logic [ATTACHED_INFO_WIDTH-1:0] att_ram [DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, free;

    logic [FETCH_SIZE-1:0][OW-1:0] off;
    logic [OW-1:0]                 enq_n, enq_cnt;
    logic                          enq;
    logic [ISSUE_WIDTH-1:0]        pop;
    logic [DW-1:0]                 deq_n;

    iq_compactor #(.N(FETCH_SIZE)) u_compactor (
        .valid  (valid_i),
        .offset (off),
        .total  (enq_n)
    );

    // ready looks only at the registered count, never at ready_i
    assign free    = CW'(DEPTH) - count;
    assign ready_o = free >= CW'(FETCH_SIZE);
    assign enq     = (|valid_i) & ready_o & ~clr_i;
    assign enq_cnt = enq ? enq_n : '0;

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
        logic [PW-1:0] idx;
        assign idx           = head + PW'(k);
        assign valid_o[k]    = count > CW'(k);
        assign pc_o[k]       = ram[idx].pc;
        assign inst_o[k]     = ram[idx].inst;
        assign adef_o[k]     = ram[idx].adef;
        assign attached_o[k] = att_ram[idx];
    end

    // in-order prefix pop: a ready_i hole stops the run
    always_comb begin
        logic run;
        run   = 1'b1;
        pop   = '0;
        deq_n = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            run    = run & valid_o[k] & ready_i[k];
            pop[k] = run;
            deq_n  = deq_n + DW'(run);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_SIZE; i++) begin
            if (enq && valid_i[i]) begin
                ram[tail + PW'(off[i])] <= '{
                    pc:   lane_pc(vpc_i, FETCH_SIZE, i),
                    inst: inst_i[i],
                    adef: fetch_excp_i.adef
                };
                att_ram[tail + PW'(off[i])] <= attached_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_cnt);
            count <= count + CW'(enq_cnt) - CW'(deq_n);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a queue scoreboard of entries.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr_i;
    logic [31:0]       vpc_i;
    logic [1:0]        valid_i;
    logic [1:0][31:0]  inst_i;
    logic [31:0]       attached_i;
    fetch_excp_t       fetch_excp_i;
    logic              ready_o;
    logic [1:0]        valid_o;
    logic [1:0][31:0]  pc_o;
    logic [1:0][31:0]  inst_o;
    logic [1:0][31:0]  attached_o;
    logic [1:0]        adef_o;
    logic [1:0]        ready_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] att;
        logic        adef;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    inst_queue #(
        .FETCH_SIZE(2), .ISSUE_WIDTH(2), .DEPTH(16), .ATTACHED_INFO_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .vpc_i(vpc_i),
        .valid_i(valid_i), .inst_i(inst_i), .attached_i(attached_i),
        .fetch_excp_i(fetch_excp_i), .ready_o(ready_o), .valid_o(valid_o),
        .pc_o(pc_o), .inst_o(inst_o), .attached_o(attached_o),
        .adef_o(adef_o), .ready_i(ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] grp_pc(input logic [31:0] vpc, input int l);
        logic [31:0] p;
        p = {vpc[31:3], 3'b000};
        p[2] = l[0];
        return p;
    endfunction

    // one cycle: drive, compare outputs with scoreboard head, update model
    task automatic step(input logic [31:0] vpc, input logic [1:0] vld,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] att, input logic adef,
                        input logic [1:0] rdy, input logic clr);
        bit run;
        int npop;
        bit exp_rdy;
        exp_t e;
        vpc_i = vpc; valid_i = vld; inst_i[0] = i0; inst_i[1] = i1;
        attached_i = att; fetch_excp_i.adef = adef;
        ready_i = rdy; clr_i = clr;
        #1;
        exp_rdy = (16 - sb.size()) >= 2;
        chk("ready_o", 32'(ready_o), 32'(exp_rdy));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("valid_o[%0d]", k), 32'(valid_o[k]), 32'(k < sb.size()));
            if (k < sb.size()) begin
                chk($sformatf("pc_o[%0d]", k), pc_o[k], sb[k].pc);
                chk($sformatf("inst_o[%0d]", k), inst_o[k], sb[k].inst);
                chk($sformatf("att_o[%0d]", k), attached_o[k], sb[k].att);
                chk($sformatf("adef_o[%0d]", k), 32'(adef_o[k]), 32'(sb[k].adef));
            end
        end
        run = 1; npop = 0;
        for (int k = 0; k < 2; k++) begin
            run = run && (k < sb.size()) && rdy[k];
            if (run) npop++;
        end
        if (clr) sb.delete();
        else begin
            repeat (npop) void'(sb.pop_front());
            if (|vld && exp_rdy)
                for (int l = 0; l < 2; l++)
                    if (vld[l]) begin
                        e.pc = grp_pc(vpc, l);
                        e.inst = l ? i1 : i0;
                        e.att = att; e.adef = adef;
                        sb.push_back(e);
                    end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic [1:0] rdy);
        step(32'h0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        rst_n = 0; clr_i = 0; vpc_i = 0; valid_i = 0; inst_i = '0;
        attached_i = 0; fetch_excp_i = '0; ready_i = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("reset valid_o", 32'(valid_o), 32'h0);
        chk("reset ready_o", 32'(ready_o), 32'h1);

        // single full group then pop both
        step(32'h1c000008, 2'b11, 32'h02800400, 32'h02800421,
             32'hA1, 1'b0, 2'b00, 1'b0);
        chk("grp pc0", pc_o[0], 32'h1c000008);
        chk("grp pc1", pc_o[1], 32'h1c00000c);
        idle(2'b11);
        chk("drained valid_o", 32'(valid_o), 32'h0);

        // compaction
        step(32'h1c000010, 2'b10, 32'h11110000, 32'h11110001,
             32'hB2, 1'b0, 2'b00, 1'b0);
        step(32'h1c000018, 2'b01, 32'h22220000, 32'h22220001,
             32'hB3, 1'b0, 2'b00, 1'b0);
        chk("cmp pc0", pc_o[0], 32'h1c000014);
        chk("cmp pc1", pc_o[1], 32'h1c000018);
        idle(2'b11);

        // flush, then fill to 15 under back-pressure
        step(32'h0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
        for (int g = 0; g < 7; g++)
            step(32'h1c001000 + 32'(g * 8), 2'b11, 32'h30000000 + 32'(2 * g),
                 32'h30000001 + 32'(2 * g), 32'(g), 1'b0, 2'b00, 1'b0);
        chk("ready at 14", 32'(ready_o), 32'h1);
        step(32'h1c001038, 2'b01, 32'h3000000e, 32'h0, 32'h7, 1'b0, 2'b00, 1'b0);
        chk("ready at 15", 32'(ready_o), 32'h0);
        step(32'h1c001040, 2'b11, 32'hdead0000, 32'hdead0001,
             32'hDD, 1'b0, 2'b00, 1'b0);
        for (int c = 0; c < 10 && sb.size() > 0; c++) idle(2'b11);
        chk("drain done", 32'(sb.size()), 32'h0);
        chk("drain valid_o", 32'(valid_o), 32'h0);

        // head/tail now at 15: group straddles the wrap
        step(32'h1c002000, 2'b11, 32'h44440000, 32'h44440001,
             32'hC4, 1'b0, 2'b00, 1'b0);
        chk("wrap pc0", pc_o[0], 32'h1c002000);
        chk("wrap pc1", pc_o[1], 32'h1c002004);
        chk("wrap inst1", inst_o[1], 32'h44440001);
        step(32'h1c002008, 2'b01, 32'h55550000, 32'h0, 32'hC5, 1'b0, 2'b00, 1'b0);

        // hole dequeue at count 3
        idle(2'b10);
        chk("hole no pop", pc_o[0], 32'h1c002000);
        idle(2'b01);
        chk("single pop", pc_o[0], 32'h1c002004);

        // count 2 -> 5, then enqueue together with clr
        step(32'h1c003000, 2'b10, 32'h0, 32'h66660001, 32'hC6, 1'b0, 2'b00, 1'b0);
        step(32'h1c003008, 2'b11, 32'h77770000, 32'h77770001,
             32'hC7, 1'b0, 2'b00, 1'b0);
        step(32'h1c003010, 2'b11, 32'h88880000, 32'h88880001,
             32'hC8, 1'b0, 2'b11, 1'b1);
        chk("clr valid_o", 32'(valid_o), 32'h0);
        chk("clr ready_o", 32'(ready_o), 32'h1);

        // exception group
        step(32'h1c004000, 2'b11, 32'h0, 32'h0, 32'hE1, 1'b1, 2'b00, 1'b0);
        chk("adef both", 32'(adef_o), 32'h3);
        idle(2'b11);
        idle(2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
